// File: rtl/lsu_pkg.sv
// lsu_pkg: size codes, sign_mask constants and FSM states shared by the LSU cache initiator.
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [3:0] SM_BYTE = 4'b0001;
  localparam logic [3:0] SM_HALF = 4'b0011;
  localparam logic [3:0] SM_WORD = 4'b0111;
  localparam int SM_SIGNED_BIT = 3;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
endpackage

// File: rtl/lsu_align_check.sv
// lsu_align_check: flags misaligned/illegal requests and builds the cache sign_mask.
module lsu_align_check
  import lsu_pkg::*;
(
  input  logic [1:0] size_i,
  input  logic [1:0] addr_lo_i,
  input  logic       write_i,
  input  logic       unsigned_i,
  output logic       bad_o,
  output logic [3:0] sign_mask_o
);
  logic sub_word;
  assign sub_word = (size_i == SZ_BYTE) | (size_i == SZ_HALF);
  assign bad_o = (size_i == SZ_HALF & addr_lo_i[0]) | (size_i == SZ_WORD & addr_lo_i != 2'b00) | (size_i == 2'd3);
  always_comb begin
    sign_mask_o = size_i == SZ_BYTE ? SM_BYTE : size_i == SZ_HALF ? SM_HALF : SM_WORD;
    sign_mask_o[SM_SIGNED_BIT] = ~write_i & ~unsigned_i & sub_word;
  end
endmodule

// File: rtl/lsu_cache_initiator.sv
// lsu_cache_initiator: one-at-a-time load/store initiator towards the data cache,
// with misalignment rejection and stall timeout.
module lsu_cache_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned STALL_SETTLE   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] addr,
  output logic [31:0] write_data,
  output logic        memwrite,
  output logic        memread,
  output logic [3:0]  sign_mask,
  input  logic [31:0] read_data,
  input  logic        clk_stall
);
  localparam int unsigned LAST = STALL_SETTLE + TIMEOUT_CYCLES - 1;
  localparam int CW = $clog2(LAST + 2);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic [3:0] sm_q, sm_d, sm;
  logic write_q, write_d, err_q, err_d, bad;
  lsu_align_check u_align (
    .size_i     (req_size),
    .addr_lo_i  (req_addr[1:0]),
    .write_i    (req_write),
    .unsigned_i (req_unsigned),
    .bad_o      (bad),
    .sign_mask_o(sm)
  );
  assign req_ready  = state_q == S_IDLE;
  assign rsp_valid  = state_q == S_DONE;
  assign memwrite   = state_q == S_ISSUE & write_q;
  assign memread    = state_q == S_ISSUE & ~write_q;
  assign addr       = addr_q;
  assign write_data = wdata_q;
  assign sign_mask  = sm_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = err_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      sm_q       <= '0;
      write_q    <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      sm_q       <= sm_d;
      write_q    <= write_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    sm_d       = sm_q;
    write_d    = write_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        // rejected requests leave the cache-side outputs untouched
        state_d    = bad ? S_DONE : S_ISSUE;
        err_d      = bad;
        rsp_data_d = '0;
        write_d    = req_write;
        if (!bad) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          sm_d    = sm;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (!(cnt_q < CW'(STALL_SETTLE))) begin
          if (!clk_stall) begin
            state_d    = S_DONE;
            rsp_data_d = write_q ? '0 : read_data;
          end else if (cnt_q == CW'(LAST)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_lsu_cache_initiator.sv
// tb_lsu_cache_initiator: directed table, randomized model comparison and reset-abort sequence.
module tb_lsu_cache_initiator;
  localparam int SS = 1;
  localparam int TO = 64;
  logic clk = 1'b0, reset_n = 1'b0;
  logic req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0] req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, read_data = 0;
  logic req_ready, rsp_valid, rsp_err, memwrite, memread, clk_stall;
  logic [31:0] rsp_data, addr, write_data;
  logic [3:0] sign_mask;
  int n_chk = 0, n_fail = 0;
  int ns_cfg = 0;
  int left;
  always #5 clk = ~clk;
  lsu_cache_initiator #(.STALL_SETTLE(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .addr(addr), .write_data(write_data),
    .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
    .read_data(read_data), .clk_stall(clk_stall)
  );
  // cache model: stall for ns_cfg cycles starting the cycle after a strobe
  always @(posedge clk or negedge reset_n)
    if (!reset_n) left <= 0;
    else if (memread | memwrite) left <= ns_cfg;
    else if (left > 0) left <= left - 1;
  assign clk_stall = left > 0;
  typedef struct {
    string nm; logic w; logic [1:0] sz; logic u;
    logic [31:0] a, wd, rd; int ns;
    logic [3:0] esm; int elat; logic eerr; logic [31:0] edata;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] rd, input int ns, output logic [3:0] esm,
                       output int elat, output logic eerr, output logic [31:0] edata);
    logic bad, tmo;
    int k;
    bad = sz == 3 || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 0);
    k = ns < SS ? SS : ns;
    tmo = !bad && k > SS + TO - 1;
    if (tmo) k = SS + TO - 1;
    esm = sz == 0 ? 4'b0001 : sz == 1 ? 4'b0011 : 4'b0111;
    if (!w && !u && sz < 2) esm[3] = 1'b1;
    elat = bad ? 1 : 3 + k;
    eerr = bad || tmo;
    edata = (bad || tmo || w) ? 32'h0 : rd;
  endtask
  task automatic run(input vec_t v);
    int c, lat, rds, wrs;
    logic hold_ok, bad;
    bad = v.eerr && v.elat == 1;
    @(negedge clk);
    chk({v.nm, " ready"}, req_ready, 1);
    req_write = v.w; req_size = v.sz; req_unsigned = v.u;
    req_addr = v.a; req_wdata = v.wd; read_data = v.rd; ns_cfg = v.ns;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0; req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rds = 0; wrs = 0; hold_ok = 1;
    for (c = 1; c <= 100 && lat == 0; c++) begin
      if (c > 1) @(negedge clk);
      rds += int'(memread); wrs += int'(memwrite);
      if ((memread | memwrite) && c != 1) hold_ok = 0;
      if (!bad && (addr !== v.a || write_data !== v.wd || sign_mask !== v.esm)) hold_ok = 0;
      if (rsp_valid) begin
        lat = c;
        chk({v.nm, " rsp_data"}, rsp_data, v.edata);
        chk({v.nm, " rsp_err"}, rsp_err, v.eerr);
        chk({v.nm, " ready_in_done"}, req_ready, 0);
      end
    end
    chk({v.nm, " latency"}, lat, v.elat);
    chk({v.nm, " memread_count"}, rds, (bad || v.w) ? 0 : 1);
    chk({v.nm, " memwrite_count"}, wrs, (!bad && v.w) ? 1 : 0);
    chk({v.nm, " cache_outputs_held"}, hold_ok, 1);
  endtask
  task automatic chk_reset_outputs(input string nm);
    chk({nm, " req_ready"}, req_ready, 1);
    chk({nm, " strobes"}, {memread, memwrite}, 0);
    chk({nm, " rsp_valid_err"}, {rsp_valid, rsp_err}, 0);
    chk({nm, " addr"}, addr, 0);
    chk({nm, " write_data"}, write_data, 0);
    chk({nm, " rsp_data"}, rsp_data, 0);
    chk({nm, " sign_mask"}, sign_mask, 0);
  endtask
  initial begin
    vec_t v;
    int nrsp;
    tbl.push_back('{"st_byte", 1, 0, 0, 32'h400, 32'hAAA, 32'h0, 0, 4'b0001, 4, 0, 32'h0});
    tbl.push_back('{"ld_sbyte_stall3", 0, 0, 0, 32'h400, 32'h0, 32'hFFFFFFAA, 3, 4'b1001, 6, 0, 32'hFFFFFFAA});
    tbl.push_back('{"ld_uhalf", 0, 1, 1, 32'h100, 32'h0, 32'h0000AAAA, 0, 4'b0011, 4, 0, 32'h0000AAAA});
    tbl.push_back('{"ld_word_mis", 0, 2, 0, 32'h102, 32'h0, 32'h1234, 0, 4'b0000, 1, 1, 32'h0});
    tbl.push_back('{"st_half_mis", 1, 1, 0, 32'h101, 32'h55, 32'h0, 0, 4'b0000, 1, 1, 32'h0});
    tbl.push_back('{"ld_size3", 0, 3, 0, 32'h200, 32'h0, 32'h1, 0, 4'b0000, 1, 1, 32'h0});
    tbl.push_back('{"ld_shalf", 0, 1, 0, 32'h2, 32'h0, 32'hFFFF8000, 1, 4'b1011, 4, 0, 32'hFFFF8000});
    tbl.push_back('{"st_half", 1, 1, 0, 32'h6, 32'hBEEF, 32'h0, 0, 4'b0011, 4, 0, 32'h0});
    tbl.push_back('{"st_word", 1, 2, 0, 32'h8, 32'hDEADBEEF, 32'h77, 2, 4'b0111, 5, 0, 32'h0});
    tbl.push_back('{"ld_sword", 0, 2, 0, 32'hC, 32'h0, 32'h89ABCDEF, 0, 4'b0111, 4, 0, 32'h89ABCDEF});
    tbl.push_back('{"ld_ubyte_stall64", 0, 0, 1, 32'h3, 32'h0, 32'h5A, 64, 4'b0001, 67, 0, 32'h5A});
    tbl.push_back('{"ld_word_stall65", 0, 2, 0, 32'h40, 32'h0, 32'h99, 65, 4'b0111, 67, 1, 32'h0});
    tbl.push_back('{"ld_word_stuck", 0, 2, 0, 32'h40, 32'h0, 32'h99, 100000, 4'b0111, 67, 1, 32'h0});
    #12;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1;
    foreach (tbl[i]) run(tbl[i]);
    for (int i = 0; i < 40; i++) begin
      v.nm = $sformatf("rand%0d", i);
      v.w = 1'($urandom); v.sz = 2'($urandom); v.u = 1'($urandom);
      v.a = $urandom; v.wd = $urandom; v.rd = $urandom;
      v.ns = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 70) : $urandom_range(0, 4);
      model(v.w, v.sz, v.u, v.a, v.rd, v.ns, v.esm, v.elat, v.eerr, v.edata);
      run(v);
    end
    @(negedge clk);
    req_write = 0; req_size = 2; req_unsigned = 0; req_addr = 32'h80;
    read_data = 32'h1111; ns_cfg = 10; req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    repeat (2) @(negedge clk);
    #2 reset_n = 0;
    #1 chk_reset_outputs("reset_in_wait");
    @(negedge clk);
    reset_n = 1;
    nrsp = 0;
    repeat (8) begin
      @(negedge clk);
      nrsp += int'(rsp_valid);
    end
    chk("reset_no_rsp", nrsp, 0);
    run(tbl[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_cache_initiator.md
Name: lsu_cache_initiator

Overview:
- Initiator side of the data-cache request interface (addr / write_data / memwrite / memread / sign_mask in; read_data / clk_stall back).
- Sits between the execute/memory pipeline stage and the data cache.
- Takes one load/store at a time over a valid/ready handshake and drives a single-cycle strobe to the cache. Holds address, data and mask stable until the cache finishes, then returns one response.
- Also detects misaligned accesses and cache-stall timeouts.

Parameters:
- STALL_SETTLE, 1: WAIT cycles in which clk_stall is ignored; covers the cache raising stall one cycle after the strobe.
- TIMEOUT_CYCLES, 64: maximum WAIT cycles with clk_stall high before the access is aborted with an error.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is illegal
- req_unsigned  in  1  load zero-extends when 1; ignored for stores and words
- req_addr  in  32  byte address
- req_wdata  in  32  store data, low-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  32  load result (already extended by the cache); 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid: misaligned, illegal size, or timeout
- addr  out  32  to cache
- write_data  out  32  to cache
- memwrite  out  1  to cache, one-cycle strobe
- memread  out  1  to cache, one-cycle strobe
- sign_mask  out  4  to cache: bit3 = signed; bits2:0 = 001 byte, 011 half, 111 word
- read_data  in  32  from cache
- clk_stall  in  1  from cache; high while the access is in progress

Behaviour:
- Reset (asynchronous, reset_n low) forces the following, mid-access included; any in-flight access is dropped with no response:
  - state IDLE, req_ready 1
  - memread, memwrite, rsp_valid, rsp_err 0
  - addr, write_data, rsp_data 0
  - sign_mask 4'b0000
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, capture the request.
  - Misaligned (half with addr[0]=1; word with addr[1:0]≠0) or req_size = 3: go to DONE with rsp_err = 1. The cache sees no strobe.
  - Otherwise go to ISSUE.
- sign_mask encoding:
  - byte: 0001
  - half: 0011
  - word: 0111
  - bit3 = ~req_unsigned for loads of byte and half; 0 otherwise.
- ISSUE (exactly 1 cycle):
  - memwrite = req_write, memread = ~req_write.
  - addr, write_data and sign_mask take the captured values.
  - Next state WAIT with the cycle counter cleared.
- WAIT:
  - Strobes are 0; addr, write_data and sign_mask stay held.
  - Counter increments each cycle.
  - Counter < STALL_SETTLE: stay.
  - Otherwise, clk_stall = 0: register read_data into rsp_data (load) or 0 (store), then go to DONE.
  - clk_stall = 1 with counter = STALL_SETTLE + TIMEOUT_CYCLES − 1: go to DONE with rsp_err = 1 and rsp_data = 0.
- DONE (1 cycle):
  - rsp_valid = 1, req_ready = 0.
  - Next state IDLE.
  - Cache-side outputs stay held through DONE and change only on the next accept.
- Latency with STALL_SETTLE = 1 and no stall:
  - accept at T0, strobe at T1, settle at T2, sample at T3, rsp_valid at T4.
  - Next accept no earlier than T5.
- Misaligned or illegal request: rsp_valid at T1.
- req_valid while not in IDLE is ignored (req_ready is 0); the requester must hold the request.
- clk_stall high during IDLE is ignored.

Decomposition:
- Shared package lsu_pkg holds:
  - size codes
  - sign_mask constants SM_BYTE = 4'b0001, SM_HALF = 4'b0011, SM_WORD = 4'b0111, SM_SIGNED_BIT = 3
  - FSM state enum
- Natural sub-module: lsu_align_check. Combinational: size/addr → misaligned flag plus sign_mask.

Test Plan:
- Byte store, addr 0x400, wdata 0xAAA, size 0 → one-cycle memwrite; sign_mask 0001; addr held until rsp_valid; rsp_err 0, rsp_data 0.
- Signed byte load, addr 0x400; cache returns 0xFFFFFFAA after 3 stall cycles → memread pulse; sign_mask 1001; rsp_data 0xFFFFFFAA.
- Unsigned half load, addr 0x100; cache returns 0x0000AAAA with no stall → sign_mask 0011; rsp_valid at T4.
- Word load at 0x102 and half store at 0x101 → no strobe; rsp_valid at T1 with rsp_err 1.
- Word load, addr 0x40, clk_stall held high forever → rsp_err 1 after STALL_SETTLE+64 WAIT cycles; block returns to IDLE.
- reset_n pulsed low during WAIT → all outputs 0 immediately; no rsp_valid; next request completes normally.
